// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: ALU opcodes, forward selects, datapath width.
package execute_stage_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // ALU opcodes carried on ALUControlE.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    // Operand forward selects; 2'b11 is unused and falls back to the register file.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Returns the forwarded operand for a given select, never X for the unused code.
    function automatic logic [XLEN_DEFAULT-1:0] fwd_select(
        input logic [1:0]              sel,
        input logic [XLEN_DEFAULT-1:0] rf_val,
        input logic [XLEN_DEFAULT-1:0] wb_val,
        input logic [XLEN_DEFAULT-1:0] mem_val
    );
        logic [XLEN_DEFAULT-1:0] val;
        case (sel)
            FWD_WB:  val = wb_val;
            FWD_MEM: val = mem_val;
            default: val = rf_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the EX stage; all arithmetic wraps modulo 2^XLEN.
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [2:0]      alu_control_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(src_a_i) < $signed(src_b_i);
    assign lt_unsigned = src_a_i < src_b_i;

    // Opcode decode; shift amount uses only the low five bits of SrcB.
    always_comb begin
        result_o = '0;
        case (alu_control_i)
            ALU_ADD:  result_o = src_a_i + src_b_i;
            ALU_SUB:  result_o = src_a_i - src_b_i;
            ALU_AND:  result_o = src_a_i & src_b_i;
            ALU_OR:   result_o = src_a_i | src_b_i;
            ALU_XOR:  result_o = src_a_i ^ src_b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_SLL:  result_o = src_a_i << src_b_i[4:0];
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, beq resolution and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] alu_result_e;
    logic            zero_e;

    logic            reg_write_q,  reg_write_d;
    logic            mem_write_q,  mem_write_d;
    logic            result_src_q, result_src_d;
    logic [4:0]      rd_q,         rd_d;
    logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;

    // Operand forwarding; the MEM source is this stage's own registered ALU result.
    always_comb begin
        src_a        = '0;
        write_data_e = '0;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = alu_result_q;
            default: write_data_e = RD2_E;
        endcase
    end

    // Immediate select happens after forwarding so stores keep forwarded rs2 data.
    assign src_b = ALUSrcE ? Imm_Ext_E : write_data_e;

    execute_stage_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .src_a_i       (src_a),
        .src_b_i       (src_b),
        .alu_control_i (ALUControlE),
        .result_o      (alu_result_e),
        .zero_o        (zero_e)
    );

    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Next-state for the EX/MEM register: capture every cycle, no stall.
    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        pc_plus4_d   = PCPlus4E;
        write_data_d = write_data_e;
        alu_result_d = alu_result_e;
    end

    // EX/MEM register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            write_data_q <= '0;
            alu_result_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            write_data_q <= write_data_d;
            alu_result_q <= alu_result_d;
        end
    end

    assign RegWriteM   = reg_write_q;
    assign MemWriteM   = mem_write_q;
    assign ResultSrcM  = result_src_q;
    assign RD_M        = rd_q;
    assign PCPlus4M    = pc_plus4_q;
    assign WriteDataM  = write_data_q;
    assign ALU_ResultM = alu_result_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RISC-V pipeline, directly downstream of the forwarding unit; consumes ForwardAE/ForwardBE.
- Selects operands from the ID/EX values, the forwarded MEM-stage ALU result, or the WB result.
- Executes the ALU operation, resolves beq branches, and drives the EX/MEM pipeline register feeding the memory stage.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- RegWriteE  input  1  register-write control from ID/EX
- MemWriteE  input  1  store control
- ResultSrcE  input  1  0 = ALU result, 1 = memory data at WB
- ALUSrcE  input  1  0 = SrcB is forwarded RD2, 1 = Imm_Ext_E
- BranchE  input  1  beq instruction
- ALUControlE  input  3  ALU opcode
- RD1_E  input  XLEN  rs1 register-file data
- RD2_E  input  XLEN  rs2 register-file data
- Imm_Ext_E  input  XLEN  sign-extended immediate
- RD_E  input  5  destination register
- PCE  input  XLEN  instruction PC
- PCPlus4E  input  XLEN  PC+4
- ForwardAE  input  2  SrcA select
- ForwardBE  input  2  SrcB select, applied before the ALUSrc mux
- ResultW  input  XLEN  WB-stage result
- PCSrcE  output  1  take branch (combinational)
- PCTargetE  output  XLEN  branch target (combinational)
- RegWriteM  output  1  registered
- MemWriteM  output  1  registered
- ResultSrcM  output  1  registered
- RD_M  output  5  registered
- PCPlus4M  output  XLEN  registered
- WriteDataM  output  XLEN  registered forwarded rs2 data
- ALU_ResultM  output  XLEN  registered ALU result, also the forwarding source

Behaviour:
- Forward mux encoding, same for A and B:
  - 00: RDx_E
  - 01: ResultW
  - 10: ALU_ResultM (current registered value)
  - 11: treated as 00
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteDataE = forwarded B, regardless of ALUSrcE.
- ALUControlE, all modulo 2^XLEN:
  - 000: add
  - 001: sub
  - 010: and
  - 011: or
  - 100: xor
  - 101: slt (signed, result 0 or 1)
  - 110: sltu
  - 111: sll by SrcB[4:0]
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE, combinational, same cycle.
- PCTargetE = PCE + Imm_Ext_E, wrap on overflow, independent of the forward muxes.
- EX/MEM register:
  - Latency 1 cycle.
  - Updates on every rising edge while rst = 1; no stall or enable.
- Reset:
  - When rst = 0 at a rising edge, all registered outputs go to 0 at that edge, including mid-instruction.
  - Combinational outputs continue to follow their inputs during reset.
  - First valid capture is the first edge with rst = 1.
- Back-to-back dependency: the value forwarded via 10 is the instruction one ahead; 01 is two ahead. Priority between the two is decided upstream; this block only obeys the select.
- RD_E = 0 is passed through unchanged. x0 suppression is handled by the forwarding unit and the register file.
- No X propagation is allowed from unused selects (11).

Decomposition:
- Shared package holds:
  - ALU opcode constants (ALU_ADD … ALU_SLL)
  - forward-select constants (FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10)
  - XLEN default
- One sub-module: alu (combinational, inputs SrcA/SrcB/ALUControl, outputs Result/Zero).
- Forward muxes and the EX/MEM register stay in execute_stage.

Test Plan:
- Reset: hold rst = 0 with nonzero inputs for 2 edges -> all M outputs 0. Release -> next edge captures RD_E = 5, ALU result 7 (RD1 = 3, RD2 = 4, add).
- Forwarding A = 10: RD1_E = 1, previous instruction produced ALU_ResultM = 0x10 -> ALU add with RD2 = 2 gives 0x12.
  - Repeat with ForwardAE = 01, ResultW = 0x20 -> 0x22.
  - Repeat with ForwardAE = 11 -> 3.
- ALUSrc/WriteData: ALUSrcE = 1, Imm = 0xFFFFFFFC, ForwardBE = 10 with ALU_ResultM = 0x55, RD1 = 8 -> ALU_ResultM = 4 and WriteDataM = 0x55.
- ALU ops:
  - slt 0xFFFFFFFF vs 1 -> 1
  - sltu same operands -> 0
  - sub 5 - 5 -> 0
  - sll 1 by 33 -> 2
  - add 0xFFFFFFFF + 1 -> 0
- Branch: BranchE = 1, sub 9 - 9 -> PCSrcE = 1 and PCTargetE = PCE 0x100 + Imm 0xFFFFFFF0 = 0xF0 in the same cycle.
  - Operands 9 vs 8 -> PCSrcE = 0.
- Mid-operation reset: three back-to-back instructions with rst pulled low on the second edge -> M outputs 0 that edge. Third instruction captured normally after release.
